tristate_line_rx: RTL and testbench
===================================

// Module: tristate_line_rx
// PURPOSE
//  Receiver at the far end of a shared 1-bit tri-state line. Remote drivers
//  put data on the line only while their enable is high, otherwise they float it (Z).
//  Block deserialises frames (start 0, 8 data LSB-first, stop 1), buffers one
//  byte behind a valid/ready handshake, and flags framing, float and overrun.
// PARAMETERS
//  CLKS_PER_BIT      4   clk cycles per line bit; >=2, even
//  SIM_FLOAT_DETECT  1   1: line===Z/X counts as FLOAT (sim); 0: FLOAT reads as 1 (pull-up)
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  line       in   1  shared tri-state line (0/1/Z)
//  rx_data    out  8  last accepted byte; stable while rx_valid=1
//  rx_valid   out  1  byte available; held until consumed
//  rx_ready   in   1  consumer accepts byte when rx_valid&rx_ready
//  busy       out  1  high in any state other than IDLE
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0
//  float_err  out  1  1-cycle pulse: line FLOAT mid-frame
//  overrun    out  1  1-cycle pulse: frame completed while buffer full
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, rx_data=8'h00, all flags 0.
//  Line classes: ZERO, ONE, FLOAT. With SIM_FLOAT_DETECT=0, FLOAT=ONE.
//  Bit timer counts 0..CLKS_PER_BIT-1. Sample point is count=CLKS_PER_BIT/2-1.
//  FSM:
//   IDLE : line ZERO -> START, timer cleared; ONE/FLOAT -> stay (idle float ok)
//   START: at mid-bit sample: ZERO -> DATA, bit_idx=0, timer re-centred;
//          ONE -> IDLE silently (glitch); FLOAT -> IDLE + float_err
//   DATA : one sample every CLKS_PER_BIT cycles; shift in LSB-first;
//          after bit_idx=7 -> STOP; FLOAT at any sample -> IDLE + float_err
//   STOP : at sample: ONE -> deliver byte, IDLE; ZERO -> frame_err, IDLE,
//          byte dropped; FLOAT -> float_err, IDLE, byte dropped
//  Deliver: if !rx_valid, or rx_valid&rx_ready in same cycle, then load rx_data
//   and set rx_valid=1 the cycle after the stop sample. Otherwise raise overrun,
//   drop the new byte and leave the old byte and rx_valid unchanged.
//  Consume: rx_valid&rx_ready with no delivery -> rx_valid=0 next cycle;
//   rx_data holds its value.
//  Latency: rx_valid rises 1 clk after the stop-bit sample,
//   i.e. 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 clks after the start falling edge.
//  Error pulses are exactly 1 cycle wide and mutually exclusive. Only ZERO
//   re-triggers START, so back-to-back frames need no gap beyond the stop bit.
//  Reset mid-frame: frame is discarded and no flag is raised.
//  Line is assumed synchronous to clk. A 2-flop synchroniser is out of scope.
// STRUCTURE
//  tri_line_defs.vh: localparams for state codes (IDLE/START/DATA/STOP),
//   FRAME_BITS=8 and the line-class encodings. It is shared with the matching driver.
//  Sub-module tri_line_bit_timer: counter with clear/re-centre and a
//   sample_tick output. The FSM, shift register and handshake stay in this module.
// TESTING  (CLKS_PER_BIT=4, TB drives line via tri-state assign enable?data:1'bz)
//  1 Frame 8'hA5, rx_ready=1 -> rx_valid pulse, rx_data=8'hA5, no flags,
//    rx_valid 39 clks after start edge
//  2 Frames 8'h3C then 8'hC3 back-to-back, rx_ready=0 -> 8'h3C kept, overrun
//    pulse once at second stop; then rx_ready=1 -> rx_valid drops
//  3 Frame 8'hFF with stop bit driven 0 -> frame_err 1 cycle, rx_valid stays 0
//  4 Enable dropped (Z) during data bit 3 -> float_err 1 cycle, IDLE; next
//    clean frame 8'h5A received correctly
//  5 1-clk low glitch on idle line -> no rx_valid, no flags, busy back to 0
//  6 rst_n low during DATA -> outputs 0 immediately; after release, frame
//    8'h81 received normally; also check simultaneous ready+delivery, no overrun

Source files
------------

// File: rtl/tristate_line_rx_pkg.sv
// tristate_line_rx_pkg: FSM states, line classes and frame constants shared by the receiver.
package tristate_line_rx_pkg;
   localparam int FRAME_BITS = 8;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   typedef enum logic [1:0] {LC_ZERO, LC_ONE, LC_FLOAT} line_class_t;
   // An undriven line is only distinguishable in a 4-state simulator; otherwise it reads as the pull-up.
   function automatic line_class_t classify(input logic l, input bit float_detect);
      if (float_detect && l !== 1'b0 && l !== 1'b1) return LC_FLOAT;
      return (l === 1'b0) ? LC_ZERO : LC_ONE;
   endfunction
endpackage

// File: rtl/tristate_line_rx_bit_timer.sv
// tristate_line_rx_bit_timer: free-running bit-period counter with mid-bit sample tick.
module tristate_line_rx_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic sample_tick
);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   logic [CW-1:0] count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count <= '0;
      else if (clr) count <= '0;
      else count <= (count == CW'(CLKS_PER_BIT - 1)) ? '0 : count + CW'(1);
   end
   assign sample_tick = !clr && (count == CW'(CLKS_PER_BIT / 2 - 1));
endmodule

// File: rtl/tristate_line_rx.sv
// tristate_line_rx: deserialises start/8-data/stop frames from a shared tri-state line
// into a one-byte valid/ready buffer, flagging framing, float and overrun errors.
module tristate_line_rx
   import tristate_line_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT     = 4,
   parameter bit SIM_FLOAT_DETECT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       line,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       frame_err,
   output logic       float_err,
   output logic       overrun
);
   state_t      state;
   line_class_t lc;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        tick;
   assign lc   = classify(line, SIM_FLOAT_DETECT);
   assign busy = (state != IDLE);
   // Holding the timer cleared while idle aligns its phase to the start edge.
   tristate_line_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk(clk),
      .rst_n(rst_n),
      .clr(state == IDLE),
      .sample_tick(tick)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         float_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         float_err <= 1'b0;
         overrun   <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         case (state)
            IDLE: if (lc == LC_ZERO) state <= START;
            START: if (tick) begin
               state     <= (lc == LC_ZERO) ? DATA : IDLE;
               bit_idx   <= '0;
               float_err <= (lc == LC_FLOAT);
            end
            DATA: if (tick) begin
               if (lc == LC_FLOAT) begin
                  state     <= IDLE;
                  float_err <= 1'b1;
               end else begin
                  shreg   <= {lc == LC_ONE, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'(FRAME_BITS - 1)) state <= STOP;
               end
            end
            STOP: if (tick) begin
               state     <= IDLE;
               frame_err <= (lc == LC_ZERO);
               float_err <= (lc == LC_FLOAT);
               // A byte consumed in the same cycle frees the buffer for the new one.
               if (lc == LC_ONE && (!rx_valid || rx_ready)) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
               end
               overrun <= (lc == LC_ONE) && rx_valid && !rx_ready;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tristate_line_rx.sv
// tb_tristate_line_rx: directed frames on a tri-state line with hand-computed expectations.
module tb_tristate_line_rx;
   localparam int CPB = 4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       d = 1'b1;
   logic       rx_ready = 1'b0;
   wire        line;
   logic [7:0] rx_data;
   logic       rx_valid, busy, frame_err, float_err, overrun;
   int         n_cmp = 0;
   int         n_err = 0;
   int         fe_cnt = 0;
   int         fl_cnt = 0;
   int         ov_cnt = 0;
   logic       four_state;

   assign line = en ? d : 1'bz;
   always #5 clk = ~clk;

   tristate_line_rx #(.CLKS_PER_BIT(CPB), .SIM_FLOAT_DETECT(1'b1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .line(line),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .busy(busy),
      .frame_err(frame_err),
      .float_err(float_err),
      .overrun(overrun)
   );

   // Count flag-high cycles so pulse width and multiplicity can be checked.
   always @(negedge clk) begin
      fe_cnt += int'(frame_err);
      fl_cnt += int'(float_err);
      ov_cnt += int'(overrun);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic line_bit(input logic v, input logic e);
      d  = v;
      en = e;
      step(CPB);
   endtask

   task automatic frame_head(input logic [7:0] b);
      line_bit(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) line_bit(b[i], 1'b1);
   endtask

   initial begin
      en = 1'b0;
      #1;
      four_state = (line !== 1'b0) && (line !== 1'b1);
      en = 1'b1;
      step(3);
      chk("reset_data", 32'(rx_data), 32'h00);
      chk("reset_valid", 32'(rx_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_flags", {29'd0, frame_err, float_err, overrun}, 32'd0);
      rst_n = 1'b1;
      step(4);

      // 1: single frame, ready high, latency 39 clks from start edge
      rx_ready = 1'b1;
      frame_head(8'hA5);
      d = 1'b1;
      step(2);
      chk("t1_valid_early", 32'(rx_valid), 32'd0);
      step(1);
      chk("t1_valid_39", 32'(rx_valid), 32'd1);
      chk("t1_data", 32'(rx_data), 32'hA5);
      step(1);
      chk("t1_valid_pulse", 32'(rx_valid), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_flags", 32'(fe_cnt + fl_cnt + ov_cnt), 32'd0);
      step(4);

      // 2: back-to-back frames with buffer full
      rx_ready = 1'b0;
      frame_head(8'h3C);
      line_bit(1'b1, 1'b1);
      chk("t2_first_valid", 32'(rx_valid), 32'd1);
      chk("t2_first_data", 32'(rx_data), 32'h3C);
      frame_head(8'hC3);
      d = 1'b1;
      step(3);
      chk("t2_overrun_pulse", 32'(overrun), 32'd1);
      chk("t2_kept_data", 32'(rx_data), 32'h3C);
      step(1);
      chk("t2_overrun_end", 32'(overrun), 32'd0);
      chk("t2_overrun_cnt", 32'(ov_cnt), 32'd1);
      rx_ready = 1'b1;
      step(1);
      chk("t2_consumed", 32'(rx_valid), 32'd0);
      chk("t2_data_hold", 32'(rx_data), 32'h3C);
      step(4);

      // 3: stop bit driven low
      frame_head(8'hFF);
      d = 1'b0;
      step(3);
      chk("t3_frame_err", 32'(frame_err), 32'd1);
      chk("t3_no_valid", 32'(rx_valid), 32'd0);
      d = 1'b1;
      step(1);
      chk("t3_frame_err_end", 32'(frame_err), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);
      chk("t3_fe_cnt", 32'(fe_cnt), 32'd1);
      step(4);

      // 4: driver releases the line from data bit 3 onwards
      line_bit(1'b0, 1'b1);
      line_bit(1'b1, 1'b1);
      line_bit(1'b0, 1'b1);
      line_bit(1'b1, 1'b1);
      en = 1'b0;
      step(3);
      chk("t4_float_err", 32'(float_err), 32'(four_state));
      step(19);
      line_bit(1'b1, 1'b1);
      line_bit(1'b1, 1'b1);
      chk("t4_fl_cnt", 32'(fl_cnt), 32'(four_state));
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_valid", 32'(rx_valid), 32'd0);
      frame_head(8'h5A);
      d = 1'b1;
      step(3);
      chk("t4_next_valid", 32'(rx_valid), 32'd1);
      chk("t4_next_data", 32'(rx_data), 32'h5A);
      step(1);
      chk("t4_next_consumed", 32'(rx_valid), 32'd0);
      step(4);

      // 5: one-clock low glitch on idle line
      d = 1'b0;
      step(1);
      d = 1'b1;
      chk("t5_busy_start", 32'(busy), 32'd1);
      step(2);
      chk("t5_busy_back", 32'(busy), 32'd0);
      step(8);
      chk("t5_valid", 32'(rx_valid), 32'd0);
      chk("t5_flags", 32'(fe_cnt + ov_cnt), 32'd2);
      chk("t5_fl_cnt", 32'(fl_cnt), 32'(four_state));

      // 6: reset during DATA, then recovery and ready coinciding with delivery
      rx_ready = 1'b0;
      line_bit(1'b0, 1'b1);
      line_bit(1'b1, 1'b1);
      line_bit(1'b0, 1'b1);
      chk("t6_busy_data", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_data", 32'(rx_data), 32'h00);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_valid", 32'(rx_valid), 32'd0);
      d = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(4);
      chk("t6_idle_after", 32'(busy), 32'd0);
      frame_head(8'h81);
      line_bit(1'b1, 1'b1);
      chk("t6_valid", 32'(rx_valid), 32'd1);
      chk("t6_data", 32'(rx_data), 32'h81);
      frame_head(8'h7E);
      d = 1'b1;
      step(2);
      rx_ready = 1'b1;
      step(1);
      chk("t6_sim_valid", 32'(rx_valid), 32'd1);
      chk("t6_sim_data", 32'(rx_data), 32'h7E);
      chk("t6_sim_no_overrun", 32'(overrun), 32'd0);
      rx_ready = 1'b0;
      step(2);
      chk("t6_held", 32'(rx_valid), 32'd1);
      chk("t6_ov_cnt", 32'(ov_cnt), 32'd1);
      chk("t6_fe_cnt", 32'(fe_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
